conv_bwd_sched: RTL

Sequencer for the 16x16 backward-convolution datapath. On a start command it fetches one 16x16 input tile and one 16x16 weight tile per channel from on-chip buffers and streams them into the datapath's enable/in/weight ports. It then waits for the datapath's completion pulse and captures a fixed-length result stream. The sequence repeats for a programmed number of channels. It sits between the layer controller (command side) and the convolution datapath plus its tile buffers (execution side).

---
 rtl/conv_bwd_sched.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/conv_bwd_sched.sv
// Backward-convolution sequencer: per channel, streams one input/weight tile pair to the datapath and captures its results.
// Define CONV_BWD_SCHED_TIMEOUT_EN to abort a job when the datapath never signals completion.
module conv_bwd_sched #(
  parameter int SIZE    = 16,
  parameter int ADDR_W  = 12,
  parameter int RES_CNT = 36
`ifdef CONV_BWD_SCHED_TIMEOUT_EN
  , parameter int TIMEOUT = 4095
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [ADDR_W-1:0]  in_base,
  input  logic [ADDR_W-1:0]  w_base,
  input  logic [3:0]         num_ch,
  output logic               busy,
  output logic               done,
  output logic               err_timeout,
  output logic               rd_en,
  output logic [ADDR_W-1:0]  in_addr,
  output logic [ADDR_W-1:0]  w_addr,
  output logic               conv_en,
  input  logic               conv_sig,
  input  logic signed [15:0] conv_result,
  output logic               res_valid,
  output logic signed [15:0] res_data,
  output logic [3:0]         res_ch
);
  localparam int BEATS   = SIZE * SIZE;
  localparam int BEAT_W  = $clog2(BEATS);
  localparam int DRAIN_W = $clog2(RES_CNT + 1);
  localparam logic [BEAT_W-1:0]  LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [DRAIN_W-1:0] LAST_RES  = DRAIN_W'(RES_CNT - 1);
  localparam logic [ADDR_W-1:0]  CH_STRIDE = ADDR_W'(BEATS);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_FLUSH, S_WAIT, S_DRAIN, S_NEXT} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   in_base_q, in_base_d, w_base_q, w_base_d;
  logic [3:0]          num_q, num_d, ch_q, ch_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [DRAIN_W-1:0]  drain_q, drain_d;
  logic                busy_q, busy_d, done_q, done_d, rd_en_q, rd_en_d, conv_en_q;
  logic [ADDR_W-1:0]   in_addr_q, in_addr_d, w_addr_q, w_addr_d;
  logic                res_valid_q, res_valid_d;
  logic signed [15:0]  res_data_q, res_data_d;
  logic [3:0]          res_ch_q, res_ch_d;
`ifdef CONV_BWD_SCHED_TIMEOUT_EN
  localparam logic [11:0] WAIT_LAST = 12'(TIMEOUT - 1);
  logic [11:0]         wait_q, wait_d;
  logic                err_q, err_d;
`endif

  // Channel c of a tile set starts c*SIZE*SIZE words past the base; the sum wraps at 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] ch_base(input logic [ADDR_W-1:0] base, input logic [3:0] ch);
    return base + ADDR_W'(ch) * CH_STRIDE;
  endfunction

  always_comb begin
    // NOTE: every _d gets a default before the case (hold for state, 0 for pulses) so no branch can infer a latch.
    state_d     = state_q;
    in_base_d   = in_base_q;
    w_base_d    = w_base_q;
    num_d       = num_q;
    ch_d        = ch_q;
    beat_d      = beat_q;
    drain_d     = drain_q;
    done_d      = 1'b0;
    rd_en_d     = 1'b0;
    in_addr_d   = in_addr_q;
    w_addr_d    = w_addr_q;
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;
    res_ch_d    = res_ch_q;
`ifdef CONV_BWD_SCHED_TIMEOUT_EN
    wait_d      = wait_q;
    err_d       = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_FETCH;
          in_base_d = in_base;
          w_base_d  = w_base;
          num_d     = (num_ch == 4'd0) ? 4'd1 : num_ch;
          ch_d      = 4'd0;
          beat_d    = '0;
          rd_en_d   = 1'b1;
          in_addr_d = in_base;
          w_addr_d  = w_base;
`ifdef CONV_BWD_SCHED_TIMEOUT_EN
          err_d     = 1'b0;
`endif
        end
      end
      S_FETCH: begin
        if (beat_q == LAST_BEAT) begin
          state_d = S_FLUSH;
        end else begin
          beat_d    = beat_q + BEAT_W'(1);
          rd_en_d   = 1'b1;
          in_addr_d = in_addr_q + ADDR_W'(1);
          w_addr_d  = w_addr_q + ADDR_W'(1);
        end
      end
      S_FLUSH: begin
        state_d = S_WAIT;
`ifdef CONV_BWD_SCHED_TIMEOUT_EN
        wait_d  = '0;
`endif
      end
      S_WAIT: begin
        if (conv_sig) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end
`ifdef CONV_BWD_SCHED_TIMEOUT_EN
        else if (wait_q == WAIT_LAST) begin
          // Abort the whole job: any remaining channels are abandoned.
          state_d = S_IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + 12'd1;
        end
`endif
      end
      S_DRAIN: begin
        res_valid_d = 1'b1;
        res_data_d  = conv_result;
        res_ch_d    = ch_q;
        if (drain_q == LAST_RES) state_d = S_NEXT;
        else                     drain_d = drain_q + DRAIN_W'(1);
      end
      S_NEXT: begin
        if (ch_q + 4'd1 == num_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d   = S_FETCH;
          ch_d      = ch_q + 4'd1;
          beat_d    = '0;
          rd_en_d   = 1'b1;
          in_addr_d = ch_base(in_base_q, ch_q + 4'd1);
          w_addr_d  = ch_base(w_base_q, ch_q + 4'd1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_base_q   <= '0;
      w_base_q    <= '0;
      num_q       <= '0;
      ch_q        <= '0;
      beat_q      <= '0;
      drain_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      conv_en_q   <= 1'b0;
      in_addr_q   <= '0;
      w_addr_q    <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_ch_q    <= '0;
    end else begin
      state_q     <= state_d;
      in_base_q   <= in_base_d;
      w_base_q    <= w_base_d;
      num_q       <= num_d;
      ch_q        <= ch_d;
      beat_q      <= beat_d;
      drain_q     <= drain_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_en_q     <= rd_en_d;
      conv_en_q   <= rd_en_q;   // buffer data arrives one cycle after the read strobe
      in_addr_q   <= in_addr_d;
      w_addr_q    <= w_addr_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_ch_q    <= res_ch_d;
    end
  end

`ifdef CONV_BWD_SCHED_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wait_q <= wait_d;
      err_q  <= err_d;
    end
  end
  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_en     = rd_en_q;
  assign in_addr   = in_addr_q;
  assign w_addr    = w_addr_q;
  assign conv_en   = conv_en_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_ch    = res_ch_q;

endmodule
